// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Shares one single-beat AXI read port between an instruction fetch unit
//   (IFU) and a load/store unit (LSU). One downstream transaction may be
//   outstanding at a time; the FSM walks IDLE -> ADDR -> DATA -> IDLE.
//   The LSU normally has priority. After STARVE_LIMIT consecutive LSU grants
//   made while the IFU was waiting, the IFU wins the next arbitration.
//   A frontend flush masks a new IFU request. If the IFU already owns the
//   port, the flush instead makes the arbiter silently drain that fetch.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   ifu_ar_* / ifu_r_*    : IFU read-address / read-data channels
//   lsu_ar_* / lsu_r_*    : LSU read-address / read-data channels
//   m_ar_* / m_r_*        : shared downstream read-address / read-data channels
//   ifu_flush             : cancels the IFU's pending or in-flight fetch
//   busy                  : high whenever a transaction is in progress
module axi_rd_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_ar_valid,
  output logic        ifu_ar_ready,
  input  logic [31:0] ifu_ar_addr,
  output logic        ifu_r_valid,
  input  logic        ifu_r_ready,
  output logic [31:0] ifu_r_data,
  output logic [1:0]  ifu_r_resp,
  input  logic        lsu_ar_valid,
  output logic        lsu_ar_ready,
  input  logic [31:0] lsu_ar_addr,
  output logic        lsu_r_valid,
  input  logic        lsu_r_ready,
  output logic [31:0] lsu_r_data,
  output logic [1:0]  lsu_r_resp,
  output logic        m_ar_valid,
  input  logic        m_ar_ready,
  output logic [31:0] m_ar_addr,
  input  logic        m_r_valid,
  output logic        m_r_ready,
  input  logic [31:0] m_r_data,
  input  logic [1:0]  m_r_resp,
  input  logic        ifu_flush,
  output logic        busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e           state_q, state_d;
  logic             owner_ifu_q, owner_ifu_d;
  logic [31:0]      addr_q, addr_d;
  logic             discard_q, discard_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic starve_full;
  logic grant_ifu;
  logic grant_lsu;
  logic discard_now;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    owner_ifu_d  = owner_ifu_q;
    addr_d       = addr_q;
    discard_d    = discard_q;
    starve_cnt_d = starve_cnt_q;
    ifu_ar_ready = 1'b0;
    lsu_ar_ready = 1'b0;
    ifu_r_valid  = 1'b0;
    lsu_r_valid  = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = '0;
    lsu_r_data   = '0;
    lsu_r_resp   = '0;
    m_ar_valid   = 1'b0;
    m_ar_addr    = addr_q;
    m_r_ready    = 1'b0;
    busy         = (state_q != IDLE);

    // A flushed IFU request simply does not take part in arbitration.
    starve_full = (starve_cnt_q == LIMIT);
    grant_ifu   = ifu_ar_valid & ~ifu_flush & (~lsu_ar_valid | starve_full);
    grant_lsu   = lsu_ar_valid & ~grant_ifu;
    // A flush arriving together with the final beat must already hide that beat.
    discard_now = discard_q | (owner_ifu_q & ifu_flush);

    case (state_q)
      IDLE: begin
        ifu_ar_ready = grant_ifu;
        lsu_ar_ready = grant_lsu;
        if (grant_ifu) begin
          owner_ifu_d = 1'b1;
          addr_d      = ifu_ar_addr;
          state_d     = ADDR;
        end else if (grant_lsu) begin
          owner_ifu_d = 1'b0;
          addr_d      = lsu_ar_addr;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        m_ar_valid = 1'b1;
        // The address phase is never retracted, even after a flush.
        if (owner_ifu_q && ifu_flush) discard_d = 1'b1;
        if (m_ar_ready) state_d = DATA;
      end
      DATA: begin
        if (owner_ifu_q) begin
          ifu_r_valid = m_r_valid & ~discard_now;
          ifu_r_data  = m_r_data;
          ifu_r_resp  = m_r_resp;
          m_r_ready   = discard_now | ifu_r_ready;
        end else begin
          lsu_r_valid = m_r_valid;
          lsu_r_data  = m_r_data;
          lsu_r_resp  = m_r_resp;
          m_r_ready   = lsu_r_ready;
        end
        if (discard_now) discard_d = 1'b1;
        if (m_r_valid && m_r_ready) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starvation counts LSU wins over a waiting IFU. A grant only happens in
    // IDLE, and the ready it raises always meets a valid.
    if (!ifu_ar_valid) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && grant_ifu) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && grant_lsu && !starve_full) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    // Handshake outputs stay quiet for the whole reset, including mid-transaction.
    if (reset) begin
      ifu_ar_ready = 1'b0;
      lsu_ar_ready = 1'b0;
      ifu_r_valid  = 1'b0;
      lsu_r_valid  = 1'b0;
      m_ar_valid   = 1'b0;
      m_r_ready    = 1'b0;
      busy         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value as it stood before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_ifu_q  <= 1'b0;
      // NOTE: the latched address is datapath, but it is cleared on reset so
      // m_ar_addr never shows a stale address from before the reset.
      addr_q       <= '0;
      discard_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_ifu_q  <= owner_ifu_d;
      addr_q       <= addr_d;
      discard_q    <= discard_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_ar_valid, ifu_ar_ready;
  logic [31:0] ifu_ar_addr;
  logic        ifu_r_valid, ifu_r_ready;
  logic [31:0] ifu_r_data;
  logic [1:0]  ifu_r_resp;
  logic        lsu_ar_valid, lsu_ar_ready;
  logic [31:0] lsu_ar_addr;
  logic        lsu_r_valid, lsu_r_ready;
  logic [31:0] lsu_r_data;
  logic [1:0]  lsu_r_resp;
  logic        m_ar_valid, m_ar_ready;
  logic [31:0] m_ar_addr;
  logic        m_r_valid, m_r_ready;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        ifu_flush;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  axi_rd_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock        (clock),
    .reset        (reset),
    .ifu_ar_valid (ifu_ar_valid),
    .ifu_ar_ready (ifu_ar_ready),
    .ifu_ar_addr  (ifu_ar_addr),
    .ifu_r_valid  (ifu_r_valid),
    .ifu_r_ready  (ifu_r_ready),
    .ifu_r_data   (ifu_r_data),
    .ifu_r_resp   (ifu_r_resp),
    .lsu_ar_valid (lsu_ar_valid),
    .lsu_ar_ready (lsu_ar_ready),
    .lsu_ar_addr  (lsu_ar_addr),
    .lsu_r_valid  (lsu_r_valid),
    .lsu_r_ready  (lsu_r_ready),
    .lsu_r_data   (lsu_r_data),
    .lsu_r_resp   (lsu_r_resp),
    .m_ar_valid   (m_ar_valid),
    .m_ar_ready   (m_ar_ready),
    .m_ar_addr    (m_ar_addr),
    .m_r_valid    (m_r_valid),
    .m_r_ready    (m_r_ready),
    .m_r_data     (m_r_data),
    .m_r_resp     (m_r_resp),
    .ifu_flush    (ifu_flush),
    .busy         (busy)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    ifu_ar_valid = 1'b0; ifu_ar_addr = '0; ifu_r_ready = 1'b0;
    lsu_ar_valid = 1'b0; lsu_ar_addr = '0; lsu_r_ready = 1'b0;
    m_ar_ready   = 1'b0; m_r_valid   = 1'b0; m_r_data = '0; m_r_resp = '0;
    ifu_flush    = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    ifu_ar_valid = 1'b1; lsu_ar_valid = 1'b1; m_r_valid = 1'b1;
    ifu_r_ready  = 1'b1; lsu_r_ready  = 1'b1;
    step();
    step();
    #1;
    total++;
    if ({busy, ifu_ar_ready, lsu_ar_ready, m_ar_valid, m_r_ready, ifu_r_valid, lsu_r_valid} !== 7'b0)
      $display("FAIL reset_outputs got %b want 0000000",
               {busy, ifu_ar_ready, lsu_ar_ready, m_ar_valid, m_r_ready, ifu_r_valid, lsu_r_valid});
    else passed++;
    total++;
    if (m_ar_addr !== 32'h0) $display("FAIL reset_addr got %h want 00000000", m_ar_addr);
    else passed++;
    reset = 1'b0;
    drive_idle();
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0000;
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h8000_1000;
    #1;
    total++;
    if ({ifu_ar_ready, lsu_ar_ready} !== 2'b01)
      $display("FAIL prio_ready got %b want 01", {ifu_ar_ready, lsu_ar_ready});
    else passed++;
    step();
    lsu_ar_valid = 1'b0;
    #1;
    total++;
    if ({busy, m_ar_valid, m_ar_addr} !== {1'b1, 1'b1, 32'h8000_1000})
      $display("FAIL prio_addr got %b %b %h want 1 1 80001000", busy, m_ar_valid, m_ar_addr);
    else passed++;
    total++;
    if ({ifu_ar_ready, lsu_ar_ready} !== 2'b00)
      $display("FAIL prio_ready_in_addr got %b want 00", {ifu_ar_ready, lsu_ar_ready});
    else passed++;
  endtask

  task automatic test_starvation();
    logic        exp_ifu [6];
    logic [31:0] exp_addr;
    int          lsu_issued;
    exp_ifu    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    lsu_issued = 0;
    do_reset();
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h1000_0000;
    ifu_r_ready  = 1'b1; lsu_r_ready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      lsu_ar_valid = 1'b1;
      lsu_ar_addr  = 32'h2000_0000 + 32'(lsu_issued * 4);
      #1;
      total++;
      if ({ifu_ar_ready, lsu_ar_ready} !== (exp_ifu[g] ? 2'b10 : 2'b01))
        $display("FAIL starve_grant%0d got %b want %b", g, {ifu_ar_ready, lsu_ar_ready},
                 exp_ifu[g] ? 2'b10 : 2'b01);
      else passed++;
      exp_addr = exp_ifu[g] ? ifu_ar_addr : lsu_ar_addr;
      step();
      if (exp_ifu[g]) ifu_ar_valid = 1'b0;
      else begin
        lsu_ar_valid = 1'b0;
        lsu_issued++;
      end
      m_ar_ready = 1'b1;
      #1;
      total++;
      if ({m_ar_valid, m_ar_addr, ifu_ar_ready, lsu_ar_ready} !== {1'b1, exp_addr, 2'b00})
        $display("FAIL starve_addr%0d got %b %h %b want 1 %h 00", g, m_ar_valid, m_ar_addr,
                 {ifu_ar_ready, lsu_ar_ready}, exp_addr);
      else passed++;
      step();
      m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 32'(g);
      step();
      m_r_valid = 1'b0;
    end
  endtask

  task automatic test_flush_idle_mask();
    do_reset();
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h7000_0000; ifu_flush = 1'b1;
    #1;
    total++;
    if ({ifu_ar_ready, lsu_ar_ready} !== 2'b00)
      $display("FAIL flush_mask_ifu got %b want 00", {ifu_ar_ready, lsu_ar_ready});
    else passed++;
    step();
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h7000_1234;
    #1;
    total++;
    if ({busy, ifu_ar_ready, lsu_ar_ready} !== 3'b001)
      $display("FAIL flush_mask_lsu got %b want 001", {busy, ifu_ar_ready, lsu_ar_ready});
    else passed++;
    step();
    lsu_ar_valid = 1'b0; ifu_flush = 1'b0;
    #1;
    total++;
    if ({m_ar_valid, m_ar_addr} !== {1'b1, 32'h7000_1234})
      $display("FAIL flush_mask_addr got %b %h want 1 70001234", m_ar_valid, m_ar_addr);
    else passed++;
  endtask

  task automatic test_flush_discard();
    do_reset();
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h3000_0000;
    #1;
    total++;
    if (ifu_ar_ready !== 1'b1) $display("FAIL discard_grant got %b want 1", ifu_ar_ready);
    else passed++;
    step();
    ifu_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; ifu_flush = 1'b1; ifu_r_ready = 1'b0;
    step();
    ifu_flush = 1'b0;
    #1;
    total++;
    if ({busy, ifu_r_valid} !== 2'b10)
      $display("FAIL discard_wait got %b want 10", {busy, ifu_r_valid});
    else passed++;
    step();
    m_r_valid = 1'b1; m_r_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({ifu_r_valid, lsu_r_valid, m_r_ready} !== 3'b001)
      $display("FAIL discard_beat got %b want 001", {ifu_r_valid, lsu_r_valid, m_r_ready});
    else passed++;
    step();
    m_r_valid = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL discard_idle got %b want 0", busy);
    else passed++;
    // Flush landing exactly on the final beat.
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h3000_0040;
    step();
    ifu_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 32'h1234_5678;
    ifu_r_ready = 1'b1; ifu_flush = 1'b1;
    #1;
    total++;
    if ({ifu_r_valid, m_r_ready} !== 2'b01)
      $display("FAIL flush_last_beat got %b want 01", {ifu_r_valid, m_r_ready});
    else passed++;
    step();
    ifu_flush = 1'b0; m_r_valid = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) $display("FAIL flush_last_idle got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_ar_backpressure();
    logic [31:0] a;
    do_reset();
    a = $urandom & 32'hFFFF_FFFC;
    lsu_ar_valid = 1'b1; lsu_ar_addr = a;
    step();
    lsu_ar_valid = 1'b0; lsu_ar_addr = ~a;
    for (int i = 0; i < 3; i++) begin
      m_ar_ready = 1'b0;
      #1;
      total++;
      if ({m_ar_valid, m_ar_addr} !== {1'b1, a})
        $display("FAIL bp_hold%0d got %b %h want 1 %h", i, m_ar_valid, m_ar_addr, a);
      else passed++;
      step();
    end
    m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_data = 32'hCAFE_0001; lsu_r_ready = 1'b1;
    #1;
    total++;
    if ({m_ar_valid, lsu_r_valid, m_r_ready, lsu_r_data} !== {3'b011, 32'hCAFE_0001})
      $display("FAIL bp_data got %b %h want 011 cafe0001",
               {m_ar_valid, lsu_r_valid, m_r_ready}, lsu_r_data);
    else passed++;
    step();
    m_r_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h4000_0000;
    step();
    lsu_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    m_r_valid = 1'b1; m_r_data = 32'h5555_AAAA; lsu_r_ready = 1'b1;
    ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h5000_0000;
    #1;
    total++;
    if ({busy, m_r_ready, lsu_r_valid, ifu_ar_ready} !== 4'b0001)
      $display("FAIL reset_mid got %b want 0001", {busy, m_r_ready, lsu_r_valid, ifu_ar_ready});
    else passed++;
    step();
    ifu_ar_valid = 1'b0;
    #1;
    total++;
    if ({m_ar_valid, m_r_ready, m_ar_addr} !== {2'b10, 32'h5000_0000})
      $display("FAIL reset_mid_regrant got %b %h want 10 50000000",
               {m_ar_valid, m_r_ready}, m_ar_addr);
    else passed++;
    m_r_valid = 1'b0;
  endtask

  task automatic test_error_resp();
    logic [31:0] d;
    do_reset();
    d = $urandom;
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h6000_0000;
    step();
    lsu_ar_valid = 1'b0; m_ar_ready = 1'b1;
    step();
    m_ar_ready = 1'b0; m_r_valid = 1'b1; m_r_resp = 2'b10; m_r_data = d; lsu_r_ready = 1'b1;
    #1;
    total++;
    if ({lsu_r_valid, lsu_r_resp, lsu_r_data} !== {1'b1, 2'b10, d})
      $display("FAIL err_resp got %b %b %h want 1 10 %h", lsu_r_valid, lsu_r_resp, lsu_r_data, d);
    else passed++;
    step();
    m_r_valid = 1'b0; m_r_resp = 2'b00;
    lsu_ar_valid = 1'b1; lsu_ar_addr = 32'h6000_0004;
    #1;
    total++;
    if ({busy, lsu_ar_ready} !== 2'b01)
      $display("FAIL err_return_idle got %b want 01", {busy, lsu_ar_ready});
    else passed++;
    step();
    lsu_ar_valid = 1'b0;
  endtask

  // Transaction-level reference: each requester holds a pending request until
  // granted; a grant happens whenever nothing is outstanding, chosen by LSU
  // priority with the starvation override; a slave answers each accepted
  // address after a random delay with data derived from the address.
  task automatic test_random();
    bit          ifu_pend, lsu_pend, out_busy, out_ifu, ar_done, slave_has;
    bit          e_ifu_rdy, e_lsu_rdy, e_mar_v, e_mrr, e_ifu_rv, e_lsu_rv;
    logic [31:0] out_addr, slave_data;
    logic [1:0]  slave_resp;
    int          cnt, slave_delay;
    ifu_pend = 0; lsu_pend = 0; out_busy = 0; out_ifu = 0; ar_done = 0; slave_has = 0;
    out_addr = '0; slave_data = '0; slave_resp = '0; cnt = 0; slave_delay = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!ifu_pend && $urandom_range(0, 3) == 0) begin
        ifu_pend = 1; ifu_ar_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsu_pend && $urandom_range(0, 3) != 0) begin
        lsu_pend = 1; lsu_ar_addr = $urandom & 32'hFFFF_FFFC;
      end
      ifu_ar_valid = ifu_pend;
      lsu_ar_valid = lsu_pend;
      m_ar_ready   = 1'($urandom_range(0, 1));
      ifu_r_ready  = ($urandom_range(0, 3) != 0);
      lsu_r_ready  = ($urandom_range(0, 3) != 0);
      m_r_valid    = slave_has && slave_delay == 0;
      m_r_data     = slave_has ? slave_data : $urandom;
      m_r_resp     = slave_resp;
      #1;
      e_ifu_rdy = !out_busy && ifu_pend && (!lsu_pend || cnt == int'(LIMIT));
      e_lsu_rdy = !out_busy && lsu_pend && !e_ifu_rdy;
      e_mar_v   = out_busy && !ar_done;
      e_mrr     = out_busy && ar_done && (out_ifu ? ifu_r_ready : lsu_r_ready);
      e_ifu_rv  = m_r_valid && out_ifu;
      e_lsu_rv  = m_r_valid && !out_ifu;
      total++;
      if ({ifu_ar_ready, lsu_ar_ready, m_ar_valid, m_r_ready, ifu_r_valid, lsu_r_valid, busy} !==
          {e_ifu_rdy, e_lsu_rdy, e_mar_v, e_mrr, e_ifu_rv, e_lsu_rv, out_busy})
        $display("FAIL rand_ctrl cycle %0d got %b want %b", c,
                 {ifu_ar_ready, lsu_ar_ready, m_ar_valid, m_r_ready, ifu_r_valid, lsu_r_valid, busy},
                 {e_ifu_rdy, e_lsu_rdy, e_mar_v, e_mrr, e_ifu_rv, e_lsu_rv, out_busy});
      else passed++;
      if (e_mar_v) begin
        total++;
        if (m_ar_addr !== out_addr)
          $display("FAIL rand_addr cycle %0d got %h want %h", c, m_ar_addr, out_addr);
        else passed++;
      end
      if (m_r_valid) begin
        total++;
        if ((out_ifu ? {ifu_r_data, ifu_r_resp} : {lsu_r_data, lsu_r_resp}) !== {slave_data, slave_resp})
          $display("FAIL rand_data cycle %0d got %h want %h", c,
                   out_ifu ? {ifu_r_data, ifu_r_resp} : {lsu_r_data, lsu_r_resp},
                   {slave_data, slave_resp});
        else passed++;
      end
      // Advance the reference to the state after this clock edge.
      if (slave_has && slave_delay > 0) slave_delay--;
      if (m_r_valid && e_mrr) begin
        out_busy = 0; ar_done = 0; slave_has = 0;
      end
      if (e_mar_v && m_ar_ready) begin
        ar_done     = 1;
        slave_has   = 1;
        slave_delay = $urandom_range(0, 3);
        slave_data  = out_addr ^ 32'hA5A5_0F0F;
        slave_resp  = 2'($urandom_range(0, 3));
      end
      if (!ifu_pend || e_ifu_rdy) cnt = 0;
      else if (e_lsu_rdy && cnt < int'(LIMIT)) cnt++;
      if (e_ifu_rdy) begin
        out_busy = 1; out_ifu = 1; out_addr = ifu_ar_addr; ifu_pend = 0;
      end else if (e_lsu_rdy) begin
        out_busy = 1; out_ifu = 0; out_addr = lsu_ar_addr; lsu_pend = 0;
      end
      step();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_priority();
    test_starvation();
    test_flush_idle_mask();
    test_flush_discard();
    test_ar_backpressure();
    test_reset_mid();
    test_error_resp();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
